// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC default and fetch state encoding
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INS_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of {pc, ins} pairs feeding decode
// ports: clk/rst_n clock and async active-low reset; flush empties the queue;
//        push/push_data write; pop reads the head; pop_data is the head (0 when empty);
//        full/empty/count report occupancy.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(DEPTH);
    count = cnt_q;
    pop_data = empty ? '0 : mem_q[rd_q];
    do_pop = pop & ~empty;
    // a pop frees the slot, so a push on a full queue still lands
    do_push = push & ~flush & (~full | do_pop);
    rd_d = flush ? '0 : do_pop ? inc(rd_q) : rd_q;
    wr_d = flush ? '0 : do_push ? inc(wr_q) : wr_q;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect, stale-response flush and instruction queue
// ports: clk/rst_n clock and async active-low reset; imem_req_* fetch request channel;
//        imem_rsp_* in-order read data; redirect_* taken branch/jump target;
//        ins_valid/ins_ready/ins/ins_pc instruction handshake to decode.
module fetch_unit import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins,
  output logic [XLEN-1:0] ins_pc
);
  localparam int CW = $clog2(DEPTH+1);
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, occ;
  logic accept, push, pop, full, empty;
  logic [2*XLEN-1:0] head;
  fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(redirect_valid), .push(push),
    .push_data({rsp_pc_q, imem_rsp_data}), .pop(pop), .pop_data(head),
    .full(full), .empty(empty), .count(occ)
  );
  always_comb begin
    target = {redirect_pc[XLEN-1:2], 2'b00};
    ins_valid = ~empty;
    ins = head[XLEN-1:0];
    ins_pc = head[2*XLEN-1:XLEN];
    pop = ~empty & ins_ready;
    // the entry leaving this cycle already frees its slot, keeping the stream back-to-back
    imem_req_valid = rst_n && state_q == FETCH && !(full && !pop) &&
                     ({1'b0, out_q} + {1'b0, occ} - (CW+1)'(pop)) < (CW+1)'(DEPTH);
    imem_req_addr = pc_q;
    accept = imem_req_valid & imem_req_ready;
    push = imem_rsp_valid & ~redirect_valid & (state_q == FETCH);
    out_d = out_q + CW'(accept) - CW'(imem_rsp_valid);
    pc_d = redirect_valid ? target : accept ? pc_q + XLEN'(INS_BYTES) : pc_q;
    // responses return in order, so the pc of the next kept response just counts up
    rsp_pc_d = redirect_valid ? target : push ? rsp_pc_q + XLEN'(INS_BYTES) : rsp_pc_q;
    drop_d = redirect_valid ? out_d : (state_q == FLUSH && imem_rsp_valid) ? drop_q - 1'b1 : drop_q;
    state_d = ((redirect_valid || state_q == FLUSH) && drop_d != '0) ? FLUSH : FETCH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
endmodule
